// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM port arbiter: default widths, requester index
// and the read-return tag carried alongside each granted read.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef logic [0:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, idx: 1'b0};

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag delay line: a tag pushed with a granted read emerges
// DEPTH cycles later, aligned with the RAM q output.
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  // Shift the tag one stage per cycle
  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Tag stages, flushed by clr so in-flight reads are dropped
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the CPU data RAM: round-robin with a bounded lock,
// one access per clock, RAM pins driven combinationally from the winner.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  req_idx_t          last_q,   last_d;
  logic              locked_q, locked_d;
  req_idx_t          owner_q,  owner_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              force_q,  force_d;

  logic              owner_req_s;
  logic              gnt_any_s;
  req_idx_t          gnt_idx_s;
  logic              sel_one_s;
  logic              sel_we_s;
  logic              sel_lock_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  rd_tag_t           tag_in_s;
  rd_tag_t           tag_out_s;

  assign owner_req_s = (owner_q == 1'b1) ? req1 : req0;

  // Winner selection: lock owner first, then round-robin on a tie
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = 1'b0;
    if (rst) begin
      gnt_any_s = 1'b0;
    end else if (locked_q && owner_req_s) begin
      gnt_any_s = 1'b1;
      gnt_idx_s = owner_q;
    end else if (req0 && req1) begin
      gnt_any_s = 1'b1;
      gnt_idx_s = ~last_q;
    end else if (req0) begin
      gnt_any_s = 1'b1;
      gnt_idx_s = 1'b0;
    end else if (req1) begin
      gnt_any_s = 1'b1;
      gnt_idx_s = 1'b1;
    end else begin
      gnt_any_s = 1'b0;
    end
  end

  // With no grant the RAM pins park on requester 0's address and data
  assign sel_one_s = gnt_any_s & gnt_idx_s[0];

  // Route the selected requester onto the RAM pins
  always_comb begin
    case (sel_one_s)
      1'b1: begin
        sel_we_s    = we1;
        sel_lock_s  = lock1;
        sel_addr_s  = addr1;
        sel_wdata_s = wdata1;
      end
      default: begin
        sel_we_s    = we0;
        sel_lock_s  = lock0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
      end
    endcase
  end

  assign gnt0      = gnt_any_s & ~gnt_idx_s[0];
  assign gnt1      = gnt_any_s &  gnt_idx_s[0];
  assign ram_wen   = gnt_any_s & sel_we_s;
  assign ram_waddr = sel_addr_s;
  assign ram_raddr = sel_addr_s;
  assign ram_wdata = sel_wdata_s;
  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Lock/ownership bookkeeping; force_d marks the cycle after a forced release
  always_comb begin
    last_d   = last_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    force_d  = 1'b0;
    if (gnt_any_s) begin
      last_d = gnt_idx_s;
      if (locked_q && (gnt_idx_s == owner_q)) begin
        if (sel_lock_s && (cnt_inc_s == LOCK_MAX_C)) begin
          locked_d = 1'b0;
          cnt_d    = CNT_ZERO;
          force_d  = 1'b1;
        end else if (sel_lock_s) begin
          cnt_d = cnt_inc_s;
        end else begin
          locked_d = 1'b0;
          cnt_d    = CNT_ZERO;
        end
      end else if (sel_lock_s && !(force_q && (gnt_idx_s == owner_q))) begin
        owner_d = gnt_idx_s;
        if (LOCK_MAX_C == CNT_ONE) begin
          locked_d = 1'b0;
          cnt_d    = CNT_ZERO;
          force_d  = 1'b1;
        end else begin
          locked_d = 1'b1;
          cnt_d    = CNT_ONE;
        end
      end else begin
        locked_d = 1'b0;
        cnt_d    = CNT_ZERO;
      end
    end else begin
      locked_d = 1'b0;
      cnt_d    = CNT_ZERO;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= 1'b1;
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= CNT_ZERO;
      force_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      force_q  <= force_d;
    end
  end

  assign tag_in_s = '{valid: gnt_any_s & ~sel_we_s, idx: gnt_idx_s};

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .clr   (rst),
    .tag_i (tag_in_s),
    .tag_o (tag_out_s)
  );

  assign rvalid0 = ~rst & tag_out_s.valid & (tag_out_s.idx == 1'b0);
  assign rvalid1 = ~rst & tag_out_s.valid & (tag_out_s.idx == 1'b1);
  assign rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a read-return
// scoreboard; grants are checked against per-step expectations.
module tb_ram_port_arbiter;

  localparam int AW       = 4;
  localparam int DW       = 4;
  localparam int RD_LAT   = 2;
  localparam int LOCK_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_wen(ram_wen),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: contents preset to index ^ 5, q delayed RD_LAT cycles
  logic [DW-1:0] mem [16] = '{4'h5, 4'h4, 4'h7, 4'h6, 4'h1, 4'h0, 4'h3, 4'h2,
                              4'hd, 4'hc, 4'hf, 4'he, 4'h9, 4'h8, 4'hb, 4'ha};
  logic [DW-1:0] q_pipe [RD_LAT];

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    q_pipe[0] <= mem[ram_raddr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign ram_rdata = q_pipe[RD_LAT-1];

  typedef struct {
    int            due;
    logic          idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [16];
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic drv(input logic r0, input logic w0, input logic l0,
                     input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic l1,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  // One clock: check grant/RAM pins and read returns mid-cycle, then advance
  task automatic step(input logic eg0, input logic eg1, input string tag);
    exp_t          e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ewen;
    @(negedge clk);
    ea   = eg1 ? addr1 : addr0;
    ed   = eg1 ? wdata1 : wdata0;
    ewen = (eg0 & we0) | (eg1 & we1);
    chk({tag, ".gnt0"},  {7'd0, gnt0}, {7'd0, eg0});
    chk({tag, ".gnt1"},  {7'd0, gnt1}, {7'd0, eg1});
    chk({tag, ".raddr"}, {4'd0, ram_raddr}, {4'd0, ea});
    chk({tag, ".waddr"}, {4'd0, ram_waddr}, {4'd0, ea});
    chk({tag, ".wdata"}, {4'd0, ram_wdata}, {4'd0, ed});
    chk({tag, ".wen"},   {7'd0, ram_wen}, {7'd0, ewen});
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk({tag, ".rvalid0"}, {7'd0, rvalid0}, {7'd0, ~e.idx});
      chk({tag, ".rvalid1"}, {7'd0, rvalid1}, {7'd0, e.idx});
      chk({tag, ".rdata"},   {4'd0, rdata}, {4'd0, e.data});
    end else begin
      chk({tag, ".no_rvalid"}, {6'd0, rvalid1, rvalid0}, 8'd0);
    end
    if (eg0 && !we0) begin
      e.due = cyc + RD_LAT; e.idx = 1'b0; e.data = shadow[addr0];
      sb.push_back(e);
    end
    if (eg1 && !we1) begin
      e.due = cyc + RD_LAT; e.idx = 1'b1; e.data = shadow[addr1];
      sb.push_back(e);
    end
    if (eg0 && we0) shadow[addr0] = wdata0;
    if (eg1 && we1) shadow[addr1] = wdata1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 4'(i) ^ 4'h5;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, "reset0");
    step(1'b0, 1'b0, "reset1");
    rst = 1'b0;

    drv(1'b0, 1'b0, 1'b0, 4'h9, 4'h3, 1'b0, 1'b0, 1'b0, 4'h4, 4'h1);
    repeat (10) step(1'b0, 1'b0, "idle");

    drv(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1, "alt");
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) step(1'b0, 1'b0, "alt_drain");

    drv(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 4'h3, 4'hA);
    step(1'b0, 1'b1, "wr1");
    drv(1'b1, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, "rd0");
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) step(1'b0, 1'b0, "wrrd_drain");

    // Leave last=1 so the locked run starts with requester 0
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h4, 4'h0);
    step(1'b0, 1'b1, "pre_lock");
    drv(1'b1, 1'b0, 1'b1, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h0);
    repeat (4) step(1'b1, 1'b0, "lock_lim");
    step(1'b0, 1'b1, "lock_rel");
    repeat (2) step(1'b1, 1'b0, "lock_regain");

    drv(1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h0);
    step(1'b0, 1'b1, "drop");
    // A fresh lock must allow four full grants before the forced release
    drv(1'b1, 1'b0, 1'b1, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0, 4'h7, 4'h0);
    repeat (4) step(1'b1, 1'b0, "relock");
    step(1'b0, 1'b1, "relock_rel");

    drv(1'b1, 1'b0, 1'b1, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (5) step(1'b1, 1'b0, "solo_lock");
    drv(1'b1, 1'b0, 1'b1, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0, 4'h9, 4'h0);
    step(1'b0, 1'b1, "force_ign");
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) step(1'b0, 1'b0, "lock_drain");

    drv(1'b1, 1'b1, 1'b0, 4'h5, 4'h7, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, "b2b_wr");
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h0);
    step(1'b0, 1'b1, "b2b_rd1");
    drv(1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, "b2b_rd0");
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (3) step(1'b0, 1'b0, "b2b_drain");

    drv(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b1, 1'b0, "pre_rst_rd");
    drv(1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0);
    rst = 1'b1;
    sb.delete();
    step(1'b0, 1'b0, "mid_rst");
    rst = 1'b0;
    step(1'b1, 1'b0, "post_rst_tie");
    drv(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    repeat (4) step(1'b0, 1'b0, "post_rst_drain");

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
